// File: rtl/acq_search_ctrl.sv
// Serial code-phase search sequencer for one correlator/power datapath.
// Frames one coherent period per phase bin and keeps the strongest bin seen so far.
module acq_search_ctrl #(
    parameter int CODE_LEN  = 2046,
    parameter int NUM_PHASE = 2046,
    parameter int PHASE_W   = 11,
    parameter int CNT_W     = 11,
    parameter int POW_LAT   = 4,
    parameter int POW_WIDTH = 48
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic                 rx_start,
    input  logic                 rx_abort,
    input  logic [POW_WIDTH-1:0] rx_threshold,
    input  logic [POW_WIDTH-1:0] rx_corr_acc,
    output logic                 tx_code_load,
    output logic [PHASE_W-1:0]   tx_code_phase,
    output logic                 tx_prn_sop,
    output logic                 tx_prn_eop,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_found,
    output logic [PHASE_W-1:0]   tx_peak_phase,
    output logic [POW_WIDTH-1:0] tx_peak_pow
);

    // state      | meaning
    // S_IDLE     | waiting for rx_start; previous results held
    // S_LOAD     | one-cycle generator reload at the current bin
    // S_ACCUM    | CODE_LEN samples framed by sop/eop
    // S_WAIT_POW | power pipeline latency after eop
    // S_CMP      | rx_corr_acc valid; update running peak
    // S_DONE     | done pulse; found valid from here on

    localparam int TMR_W = (CNT_W > $clog2(POW_LAT + 1)) ? CNT_W : $clog2(POW_LAT + 1);
    localparam logic [TMR_W-1:0]   ACC_LOAD  = TMR_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0]   WAIT_LOAD = TMR_W'((POW_LAT > 1) ? (POW_LAT - 2) : 0);
    localparam logic [PHASE_W-1:0] LAST_BIN  = PHASE_W'(NUM_PHASE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_WAIT_POW,
        S_CMP,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [TMR_W-1:0]     tmr, tmr_nxt;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic [PHASE_W-1:0]   peak_phase, peak_phase_nxt;
    logic [POW_WIDTH-1:0] peak_pow, peak_pow_nxt;
    logic [POW_WIDTH-1:0] thr, thr_nxt;
    logic                 found, found_nxt;

    logic                 tmr_tc;
    logic                 last_bin;
    logic                 new_peak;
    logic [POW_WIDTH-1:0] best_pow;

    assign tmr_tc   = (tmr == '0);
    assign last_bin = (phase == LAST_BIN);
    assign new_peak = (rx_corr_acc > peak_pow);
    assign best_pow = new_peak ? rx_corr_acc : peak_pow;

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state      <= S_IDLE;
            tmr        <= '0;
            phase      <= '0;
            peak_phase <= '0;
            peak_pow   <= '0;
            thr        <= '0;
            found      <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            phase      <= phase_nxt;
            peak_phase <= peak_phase_nxt;
            peak_pow   <= peak_pow_nxt;
            thr        <= thr_nxt;
            found      <= found_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tmr_nxt        = tmr;
        phase_nxt      = phase;
        peak_phase_nxt = peak_phase;
        peak_pow_nxt   = peak_pow;
        thr_nxt        = thr;
        found_nxt      = found;
        tx_code_load   = 1'b0;
        tx_prn_sop     = 1'b0;
        tx_prn_eop     = 1'b0;
        tx_done        = 1'b0;
        tx_busy        = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (rx_start && !rx_abort) begin
                    state_nxt      = S_LOAD;
                    phase_nxt      = '0;
                    peak_phase_nxt = '0;
                    peak_pow_nxt   = '0;
                    found_nxt      = 1'b0;
                    thr_nxt        = rx_threshold;
                end
            end
            S_LOAD: begin
                tx_code_load = 1'b1;
                tmr_nxt      = ACC_LOAD;
                state_nxt    = S_ACCUM;
            end
            S_ACCUM: begin
                // Timer counts down, so the first sample sits at the reload value.
                tx_prn_sop = (tmr == ACC_LOAD);
                tx_prn_eop = tmr_tc;
                if (tmr_tc) begin
                    tmr_nxt   = WAIT_LOAD;
                    state_nxt = (POW_LAT > 1) ? S_WAIT_POW : S_CMP;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            S_WAIT_POW: begin
                if (tmr_tc) begin
                    state_nxt = S_CMP;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            S_CMP: begin
                if (new_peak) begin
                    peak_pow_nxt   = rx_corr_acc;
                    peak_phase_nxt = phase;
                end
                if (last_bin) begin
                    found_nxt = (best_pow > thr);
                    state_nxt = S_DONE;
                end else begin
                    phase_nxt = phase + PHASE_W'(1);
                    state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                tx_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort freezes the results exactly as they stood before this cycle.
        if (rx_abort && (state != S_IDLE)) begin
            state_nxt      = S_IDLE;
            phase_nxt      = phase;
            peak_phase_nxt = peak_phase;
            peak_pow_nxt   = peak_pow;
            found_nxt      = found;
        end
    end

    assign tx_code_phase = phase;
    assign tx_peak_phase = peak_phase;
    assign tx_peak_pow   = peak_pow;
    assign tx_found      = found;

endmodule
